fetch_unit: RTL and testbench

- F stage of the P5 five-stage MIPS pipeline: owns the PC, issues instruction-memory reads, and holds the F/D pipeline register.
- The F/D register feeds the D-stage decoder and comparator.
- Computes the next PC from D-stage redirect requests (branch, j/jal, jr/jalr) and from stall/flush from the hazard unit.
- Absorbs variable-latency imem replies by inserting bubbles into D and latching any redirect that would otherwise be lost.

---
 rtl/cpu_defs_pkg.sv | 18 +
 rtl/fetch_unit_npc_calc.sv | 46 ++++
 rtl/fetch_unit.sv | 83 ++++++++
 tb/tb_fetch_unit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the P5 pipeline front end.
// The decoder uses the same next-PC select encodings.
package cpu_defs;

    localparam logic [2:0] NPC_SEQ = 3'b000;
    localparam logic [2:0] NPC_BR  = 3'b001;
    localparam logic [2:0] NPC_J   = 3'b010;
    localparam logic [2:0] NPC_JR  = 3'b100;

    localparam logic [31:0] PC_RESET  = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_npc_calc.sv
// Next-PC target computation from the instruction held in D.
// Purely combinational; the caller gates the request with D_valid and stall.
module npc_calc
    import cpu_defs::*;
(
    input  logic [31:0] d_pc,
    input  logic [2:0]  sel,
    input  logic        br_taken,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    input  logic [31:0] rs_fwd,
    output logic [31:0] tgt,
    output logic        redir_req
);

    logic [31:0] br_off;
    logic [31:0] pc_plus4;

    assign br_off   = {{14{imm16[15]}}, imm16, 2'b00};
    assign pc_plus4 = d_pc + 32'd4;

    // Unknown select codes fall through to sequential fetch.
    always_comb begin
        tgt       = '0;
        redir_req = 1'b0;
        unique case (1'b1)
            (sel == NPC_BR): begin
                tgt       = pc_plus4 + br_off;
                redir_req = br_taken;
            end
            (sel == NPC_J): begin
                tgt       = {d_pc[31:28], imm26, 2'b00};
                redir_req = 1'b1;
            end
            (sel == NPC_JR): begin
                tgt       = rs_fwd;
                redir_req = 1'b1;
            end
            default: begin
                tgt       = '0;
                redir_req = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// F stage: PC register, imem request, F/D pipeline register.
// A redirect seen while imem is busy is parked in pend_tgt.
module fetch_unit
    import cpu_defs::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        D_stall,
    input  logic        D_flush,
    input  logic [2:0]  D_npc_sel,
    input  logic        D_br_taken,
    input  logic [15:0] D_imm16,
    input  logic [25:0] D_imm26,
    input  logic [31:0] D_rs_fwd,
    output logic [31:0] D_pc,
    output logic [31:0] D_instr,
    output logic        D_valid
);

    logic [31:0]  f_pc;
    logic [31:0]  pend_tgt;
    fetch_state_t state;
    logic [31:0]  tgt;
    logic         redir_req;
    logic         redir;

    npc_calc u_npc (
        .d_pc      (D_pc),
        .sel       (D_npc_sel),
        .br_taken  (D_br_taken),
        .imm16     (D_imm16),
        .imm26     (D_imm26),
        .rs_fwd    (D_rs_fwd),
        .tgt       (tgt),
        .redir_req (redir_req)
    );

    assign redir     = D_valid & redir_req & ~D_stall;
    assign imem_addr = f_pc;
    assign imem_req  = ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            f_pc     <= PC_RESET;
            pend_tgt <= '0;
            state    <= RUN;
            D_pc     <= '0;
            D_instr  <= NOP_INSTR;
            D_valid  <= 1'b0;
        end else if (!D_stall) begin
            if (imem_ready) begin
                if (D_flush) begin
                    D_instr <= NOP_INSTR;
                    D_valid <= 1'b0;
                end else begin
                    D_pc    <= f_pc;
                    D_instr <= imem_rdata;
                    D_valid <= 1'b1;
                end
                if (state == PEND)
                    f_pc <= pend_tgt;
                else if (redir)
                    f_pc <= tgt;
                else
                    f_pc <= f_pc + 32'd4;
                state <= RUN;
            end else begin
                D_instr <= NOP_INSTR;
                D_valid <= 1'b0;
                // D only holds bubbles in PEND, so only RUN can latch.
                if (redir && state == RUN) begin
                    pend_tgt <= tgt;
                    state    <= PEND;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit.
// imem is modelled as a combinational lookup of the fetch address.
module tb_fetch_unit;
    import cpu_defs::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        D_stall;
    logic        D_flush;
    logic [2:0]  D_npc_sel;
    logic        D_br_taken;
    logic [15:0] D_imm16;
    logic [25:0] D_imm26;
    logic [31:0] D_rs_fwd;
    logic [31:0] D_pc;
    logic [31:0] D_instr;
    logic        D_valid;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[15:0], 16'hC0DE};
    endfunction

    assign imem_rdata = word(imem_addr);

    fetch_unit dut (
        .clk        (clk),
        .reset      (reset),
        .imem_addr  (imem_addr),
        .imem_req   (imem_req),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .D_stall    (D_stall),
        .D_flush    (D_flush),
        .D_npc_sel  (D_npc_sel),
        .D_br_taken (D_br_taken),
        .D_imm16    (D_imm16),
        .D_imm26    (D_imm26),
        .D_rs_fwd   (D_rs_fwd),
        .D_pc       (D_pc),
        .D_instr    (D_instr),
        .D_valid    (D_valid)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        imem_ready = 1'b1;
        D_stall    = 1'b0;
        D_flush    = 1'b0;
        D_npc_sel  = NPC_SEQ;
        D_br_taken = 1'b0;
        D_imm16    = '0;
        D_imm26    = '0;
        D_rs_fwd   = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        tests++; if (imem_addr !== 32'h3000) begin fails++; $display("FAIL reset_pc got=%h exp=%h", imem_addr, 32'h3000); end
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        tests++; if (D_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", D_valid); end
        tests++; if (D_instr !== 32'h0) begin fails++; $display("FAIL reset_instr got=%h exp=0", D_instr); end
        tests++; if (D_pc !== 32'h0) begin fails++; $display("FAIL reset_dpc got=%h exp=0", D_pc); end
        reset = 1'b0;
        #1;
        tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL run_req got=%b exp=1", imem_req); end
    endtask

    task automatic test_seq();
        do_reset();
        step();
        tests++; if (imem_addr !== 32'h3004) begin fails++; $display("FAIL seq_pc1 got=%h exp=%h", imem_addr, 32'h3004); end
        tests++; if (D_pc !== 32'h3000) begin fails++; $display("FAIL seq_dpc1 got=%h exp=%h", D_pc, 32'h3000); end
        tests++; if (D_instr !== 32'h3000C0DE) begin fails++; $display("FAIL seq_instr1 got=%h exp=%h", D_instr, 32'h3000C0DE); end
        tests++; if (D_valid !== 1'b1) begin fails++; $display("FAIL seq_valid1 got=%b exp=1", D_valid); end
        step();
        tests++; if (imem_addr !== 32'h3008) begin fails++; $display("FAIL seq_pc2 got=%h exp=%h", imem_addr, 32'h3008); end
        tests++; if (D_pc !== 32'h3004) begin fails++; $display("FAIL seq_dpc2 got=%h exp=%h", D_pc, 32'h3004); end
    endtask

    task automatic test_branch();
        do_reset();
        step();
        D_npc_sel = NPC_BR; D_br_taken = 1'b1; D_imm16 = 16'h0003;
        step();
        tests++; if (D_pc !== 32'h3004) begin fails++; $display("FAIL br_slot_dpc got=%h exp=%h", D_pc, 32'h3004); end
        tests++; if (imem_addr !== 32'h3010) begin fails++; $display("FAIL br_tgt got=%h exp=%h", imem_addr, 32'h3010); end
        D_npc_sel = NPC_SEQ;
        step();
        tests++; if (D_pc !== 32'h3010) begin fails++; $display("FAIL br_tgt_dpc got=%h exp=%h", D_pc, 32'h3010); end
        D_npc_sel = NPC_BR; D_br_taken = 1'b0; D_imm16 = 16'hFFFF;
        step();
        tests++; if (imem_addr !== 32'h3018) begin fails++; $display("FAIL br_nt got=%h exp=%h", imem_addr, 32'h3018); end
        D_br_taken = 1'b1; D_imm16 = 16'hFFFE;
        step();
        tests++; if (imem_addr !== 32'h3010) begin fails++; $display("FAIL br_neg got=%h exp=%h", imem_addr, 32'h3010); end
        tests++; if (D_pc !== 32'h3018) begin fails++; $display("FAIL br_neg_dpc got=%h exp=%h", D_pc, 32'h3018); end
        D_npc_sel = NPC_SEQ; D_br_taken = 1'b0;
    endtask

    task automatic test_stall_jr();
        do_reset();
        step();
        D_npc_sel = NPC_JR; D_rs_fwd = 32'h0000_3400; D_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            tests++; if (imem_addr !== 32'h3004) begin fails++; $display("FAIL stall_pc%0d got=%h exp=%h", i, imem_addr, 32'h3004); end
            tests++; if (D_pc !== 32'h3000 || D_valid !== 1'b1) begin fails++; $display("FAIL stall_d%0d got=%h/%b exp=%h/1", i, D_pc, D_valid, 32'h3000); end
        end
        D_stall = 1'b0;
        step();
        tests++; if (D_pc !== 32'h3004) begin fails++; $display("FAIL jr_slot got=%h exp=%h", D_pc, 32'h3004); end
        tests++; if (imem_addr !== 32'h3400) begin fails++; $display("FAIL jr_tgt got=%h exp=%h", imem_addr, 32'h3400); end
        D_npc_sel = NPC_SEQ;
        step();
        tests++; if (D_pc !== 32'h3400) begin fails++; $display("FAIL jr_tgt_dpc got=%h exp=%h", D_pc, 32'h3400); end
    endtask

    task automatic test_j_wait();
        do_reset();
        step();
        D_npc_sel = NPC_J; D_imm26 = 26'h0000C10; imem_ready = 1'b0;
        step();
        D_npc_sel = NPC_SEQ;
        tests++; if (D_valid !== 1'b0 || D_instr !== 32'h0) begin fails++; $display("FAIL jw_bubble0 got=%b/%h exp=0/0", D_valid, D_instr); end
        step();
        step();
        tests++; if (D_valid !== 1'b0) begin fails++; $display("FAIL jw_bubble2 got=%b exp=0", D_valid); end
        tests++; if (imem_addr !== 32'h3004) begin fails++; $display("FAIL jw_hold got=%h exp=%h", imem_addr, 32'h3004); end
        imem_ready = 1'b1;
        step();
        tests++; if (D_pc !== 32'h3004 || D_valid !== 1'b1) begin fails++; $display("FAIL jw_slot got=%h/%b exp=%h/1", D_pc, D_valid, 32'h3004); end
        tests++; if (imem_addr !== 32'h3040) begin fails++; $display("FAIL jw_tgt got=%h exp=%h", imem_addr, 32'h3040); end
        step();
        tests++; if (D_pc !== 32'h3040) begin fails++; $display("FAIL jw_tgt_dpc got=%h exp=%h", D_pc, 32'h3040); end
    endtask

    task automatic test_flush();
        do_reset();
        step();
        D_flush = 1'b1;
        step();
        tests++; if (D_valid !== 1'b0 || D_instr !== 32'h0) begin fails++; $display("FAIL flush_d got=%b/%h exp=0/0", D_valid, D_instr); end
        tests++; if (imem_addr !== 32'h3008) begin fails++; $display("FAIL flush_pc got=%h exp=%h", imem_addr, 32'h3008); end
        D_flush = 1'b0;
        step();
        D_flush = 1'b1; D_stall = 1'b1;
        step();
        tests++; if (D_valid !== 1'b1 || D_pc !== 32'h3008) begin fails++; $display("FAIL flstall_d got=%b/%h exp=1/%h", D_valid, D_pc, 32'h3008); end
        tests++; if (imem_addr !== 32'h300C) begin fails++; $display("FAIL flstall_pc got=%h exp=%h", imem_addr, 32'h300C); end
        D_flush = 1'b0; D_stall = 1'b0;
    endtask

    task automatic test_reset_pend();
        do_reset();
        step();
        D_npc_sel = NPC_J; D_imm26 = 26'h0000100; imem_ready = 1'b0;
        step();
        D_npc_sel = NPC_SEQ;
        reset = 1'b1;
        step();
        tests++; if (imem_addr !== 32'h3000) begin fails++; $display("FAIL rp_pc got=%h exp=%h", imem_addr, 32'h3000); end
        reset = 1'b0; imem_ready = 1'b1;
        step();
        tests++; if (imem_addr !== 32'h3004) begin fails++; $display("FAIL rp_next got=%h exp=%h", imem_addr, 32'h3004); end
        tests++; if (D_pc !== 32'h3000) begin fails++; $display("FAIL rp_dpc got=%h exp=%h", D_pc, 32'h3000); end
        step();
        tests++; if (imem_addr !== 32'h3008) begin fails++; $display("FAIL rp_seq got=%h exp=%h", imem_addr, 32'h3008); end
    endtask

    initial begin
        test_reset();
        test_seq();
        test_branch();
        test_stall_jr();
        test_j_wait();
        test_flush();
        test_reset_pend();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
